rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource between 8 requesters.
- Produces a registered one-hot grant plus its 3-bit encoded index, with the same one-hot to index mapping as the 8-to-3 encoder: bit k maps to index k.
- Grant is held until the owner signals done or drops its request.
- Sits in front of any shared port (e.g. a memory or bus master port) in the CPU datapath.

Parameters:
- MAX_HOLD, 16, maximum grant duration in cycles when ARB_TIMEOUT_EN is defined; legal range 2..256.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit k = requester k, level-sensitive.
- done  input  1  owner finished; sampled only in GRANT state.
- grant  output  8  one-hot grant, registered; all zero when idle.
- grant_idx  output  3  encoded index of grant; 0 when grant_valid=0.
- grant_valid  output  1  1 when grant is non-zero.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE; grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - last_idx=7, so index 0 has first priority; hold_cnt=0.
- State IDLE:
  - If req != 0, select the first set bit scanning last_idx+1, last_idx+2, ... mod 8 (wraps 7->0).
  - On the next edge: grant = onehot(sel), grant_idx = sel, grant_valid = 1, last_idx = sel, state = GRANT, hold_cnt = 0.
  - If req == 0: stay in IDLE, outputs stay 0.
  - Latency is 1 cycle from request sampled to grant visible.
- State GRANT:
  - Release condition: done=1, or req[grant_idx]=0.
  - On release: next edge returns to IDLE and clears grant, grant_idx and grant_valid.
  - Other req bits are ignored while in GRANT; there is no preemption.
  - hold_cnt increments each GRANT cycle, saturating at 2^CNT_W-1.
- Handover:
  - At least 1 idle cycle (grant=0) always separates two grants.
  - Minimum period between consecutive grants is 2 cycles.
- Fairness:
  - With all 8 requesting continuously and done asserted on each grant's first cycle, grant order is 0,1,2,...,7,0,...
  - No requester waits more than 7 other grants.
- Simultaneous events:
  - done=1 together with req[grant_idx]=0 is a single release.
  - A requester that releases and re-requests immediately goes to the back of the rotation.
- Reset mid-grant: grant drops asynchronously; priority pointer returns to 7.
- Invariants:
  - grant has at most one bit set.
  - grant_valid == |grant.
  - grant_idx equals the encoding of grant whenever grant_valid=1.
- X-handling: no X on outputs after reset; req bits must be known values (no defaulting to x).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt == MAX_HOLD-1 and no release condition holds, the next edge forces return to IDLE.
  - timeout=1 for exactly that one cycle (coincident with grant clearing).
  - The timed-out requester keeps its place as last_idx, so it gets lowest priority next round.
  - A grant therefore lasts at most MAX_HOLD cycles.
- Not defined:
  - No hold counter logic (may be removed); timeout tied to 0.
  - Grant held indefinitely until release.

Test Plan:
- Reset then req=8'b0000_0001 -> one cycle later grant=8'h01, grant_idx=0, grant_valid=1; done pulse -> next cycle grant=0.
- req=8'hFF held, done=1 on every grant's first cycle -> grant_idx sequence 0,1,...,7,0, each grant separated by one zero-grant cycle.
- Owner 3 granted, req=8'b0000_1000 then req[3] dropped without done -> grant clears next cycle; requester 2 raised during GRANT is not granted until after the idle cycle.
- last_idx=6, req=8'b0100_0001 -> grant_idx=0 (wrap past 7), not 6.
- resetn pulsed low while grant=8'h20 -> grant=0 immediately; after release with req=8'hFF, first grant_idx=0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h04 held, done=0 -> grant active exactly 4 cycles, timeout=1 for one cycle, grant=0; next grant goes to idx 2 again only if no other req; with req=8'h0C, idx 3 is granted next.

Source files
------------

// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
//
// Round-robin arbiter sharing one resource (memory port, bus master port, ...)
// between eight requesters. A grant is issued one cycle after a request is
// seen in IDLE and is held until the owner raises done or drops its request.
// Every grant is followed by at least one idle cycle, so the minimum period
// between consecutive grants is two cycles.
//
// Priority: the search for the next owner starts one past the most recently
// granted index (last_idx) and wraps 7 -> 0. last_idx resets to 7, so
// requester 0 has first priority out of reset. A requester that releases and
// immediately re-requests therefore goes to the back of the rotation.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Defined     - a grant lasts at most MAX_HOLD cycles; on forced release
//                 timeout pulses high for one cycle, coincident with grant
//                 clearing. The timed-out requester stays as last_idx and so
//                 has lowest priority in the next round.
//   Not defined - no hold counter; timeout is tied to 0 and a grant is held
//                 indefinitely until release.
//
// Parameters:
//   MAX_HOLD    - maximum grant duration in cycles (2..256), timeout build only
//   CNT_W       - width of the hold counter, 2**CNT_W >= MAX_HOLD
//
// Ports:
//   clk         in   1  system clock, rising edge
//   resetn      in   1  asynchronous active-low reset
//   req         in   8  level-sensitive request vector, bit k = requester k
//   done        in   1  owner finished, only looked at while granting
//   grant       out  8  registered one-hot grant, zero when idle
//   grant_idx   out  3  encoded index of grant (bit k -> k), 0 when idle
//   grant_valid out  1  high whenever grant is non-zero
//   timeout     out  1  one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   // Parameter sanity check at elaboration time.
   if ((MAX_HOLD < 2) || (MAX_HOLD > 256) || (CNT_W < 1) ||
       ((CNT_W < 31) && ((1 << CNT_W) < MAX_HOLD))) begin : g_bad_params
      $error("rr_arbiter8: MAX_HOLD must be 2..256 and fit in CNT_W bits");
   end

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t     state;
   logic [2:0] last_idx;
   logic       sel_found;
   logic [2:0] sel_idx;
   logic       release_req;

   // Round-robin pick: scan from the farthest position (last itself) towards
   // the nearest (last+1) so that the final hit is the highest priority one.
   function automatic logic [3:0] rr_pick(input logic [7:0] r,
                                          input logic [2:0] last);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int i = 8; i >= 1; i--) begin
         idx = last + 3'(i);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   always_comb begin
      {sel_found, sel_idx} = rr_pick(req, last_idx);
      // done together with a dropped request is simply one release.
      release_req = done | ~req[grant_idx];
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [CNT_W-1:0] hold_cnt;
   logic             hold_expired;

   assign hold_expired = (hold_cnt == HOLD_LAST);

   // Counts grant cycles; zero on the first visible grant cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_cnt <= '0;
      end else if (state == S_IDLE) begin
         hold_cnt <= '0;
      end else if (hold_cnt != CNT_MAX) begin
         hold_cnt <= hold_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timeout <= 1'b0;
      end else begin
         timeout <= (state == S_GRANT) && !release_req && hold_expired;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         grant       <= 8'd0;
         grant_idx   <= 3'd0;
         grant_valid <= 1'b0;
         last_idx    <= 3'd7;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  state       <= S_GRANT;
                  grant       <= 8'd1 << sel_idx;
                  grant_idx   <= sel_idx;
                  grant_valid <= 1'b1;
                  last_idx    <= sel_idx;
               end
            end
            S_GRANT: begin
               // Other requests are ignored here: no preemption.
               if (release_req) begin
                  state       <= S_IDLE;
                  grant       <= 8'd0;
                  grant_idx   <= 3'd0;
                  grant_valid <= 1'b0;
               end
`ifdef ARB_TIMEOUT_EN
               else if (hold_expired) begin
                  // Forced release; last_idx keeps the timed-out owner.
                  state       <= S_IDLE;
                  grant       <= 8'd0;
                  grant_idx   <= 3'd0;
                  grant_valid <= 1'b0;
               end
`endif
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   rr_arbiter8 #(
      .MAX_HOLD(MAX_HOLD),
      .CNT_W   (8)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .done       (done),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_valid(grant_valid),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] grant;
      logic [2:0] idx;
      logic       valid;
      logic       to;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [2:0] enc(input logic [7:0] g);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (g[i]) r = 3'(i);
      end
      return r;
   endfunction

   function automatic logic [7:0] oh(input int k);
      logic [2:0] b;
      b = 3'(k % 8);
      return 8'd1 << b;
   endfunction

   task automatic push(input logic [7:0] g, input logic to, input string tag);
      exp_t e;
      e.grant = g;
      e.idx   = enc(g);
      e.valid = |g;
      e.to    = to;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty: observed %0d entries, expected >0", sb.size());
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         assert (grant === e.grant) else begin
            errors++;
            $error("FAIL %s.grant: observed %h expected %h", e.tag, grant, e.grant);
         end
         checks++;
         assert (grant_idx === e.idx) else begin
            errors++;
            $error("FAIL %s.grant_idx: observed %0d expected %0d", e.tag, grant_idx, e.idx);
         end
         checks++;
         assert (grant_valid === e.valid) else begin
            errors++;
            $error("FAIL %s.grant_valid: observed %b expected %b", e.tag, grant_valid, e.valid);
         end
         checks++;
         assert (timeout === e.to) else begin
            errors++;
            $error("FAIL %s.timeout: observed %b expected %b", e.tag, timeout, e.to);
         end
         checks++;
         assert ($onehot0(grant) && (grant_valid === (|grant))) else begin
            errors++;
            $error("FAIL %s.invariant: observed grant %h valid %b expected onehot0 with valid==|grant",
                   e.tag, grant, grant_valid);
         end
      end
   endtask

   // Drive one cycle of stimulus, queue what must appear after the edge.
   task automatic cyc(input logic [7:0] r, input logic d, input logic [7:0] g,
                      input logic to, input string tag);
      req  = r;
      done = d;
      push(g, to, tag);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   // Asynchronous reset pulse taken between clock edges.
   task automatic pulse_reset(input string tag);
      req    = 8'd0;
      done   = 1'b0;
      resetn = 1'b0;
      #1;
      push(8'd0, 1'b0, tag);
      check_pop();
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      req    = 8'd0;
      done   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      push(8'd0, 1'b0, "reset_state");
      check_pop();
      resetn = 1'b1;

      // Single requester, done pulse.
      cyc(8'h01, 1'b0, 8'h01, 1'b0, "single_grant");
      cyc(8'h01, 1'b1, 8'h00, 1'b0, "single_done");
      cyc(8'h00, 1'b0, 8'h00, 1'b0, "single_idle");

      // Full rotation from reset, each grant separated by an idle cycle.
      pulse_reset("reset_before_rot");
      for (int k = 0; k < 9; k++) begin
         cyc(8'hFF, 1'b1, oh(k), 1'b0, $sformatf("rot_grant%0d", k));
         cyc(8'hFF, 1'b1, 8'h00, 1'b0, $sformatf("rot_gap%0d", k));
      end

      // Owner 3, requester 2 raised while granted, then req[3] dropped.
      pulse_reset("reset_before_own3");
      cyc(8'h08, 1'b0, 8'h08, 1'b0, "own3_grant");
      cyc(8'h0C, 1'b0, 8'h08, 1'b0, "own3_no_preempt");
      cyc(8'h04, 1'b0, 8'h00, 1'b0, "own3_drop");
      cyc(8'h04, 1'b0, 8'h04, 1'b0, "own2_after_idle");
      cyc(8'h04, 1'b1, 8'h00, 1'b0, "own2_done");

      // Wrap: last_idx=6 with requesters 0 and 6.
      pulse_reset("reset_before_wrap");
      cyc(8'h40, 1'b0, 8'h40, 1'b0, "wrap_set6");
      cyc(8'h40, 1'b1, 8'h00, 1'b0, "wrap_rel6");
      cyc(8'h41, 1'b0, 8'h01, 1'b0, "wrap_pick0");
      cyc(8'h41, 1'b1, 8'h00, 1'b0, "wrap_rel0");
      cyc(8'h41, 1'b0, 8'h40, 1'b0, "wrap_pick6");
      cyc(8'h41, 1'b1, 8'h00, 1'b0, "wrap_rel6b");

      // Reset mid-grant while requester 5 owns the resource.
      pulse_reset("reset_before_mid");
      cyc(8'h20, 1'b0, 8'h20, 1'b0, "mid_grant5");
      pulse_reset("mid_async_clear");
      cyc(8'hFF, 1'b0, 8'h01, 1'b0, "mid_first0");

      // done together with dropped request is one release; then re-request.
      cyc(8'hFE, 1'b1, 8'h00, 1'b0, "simul_release");
      cyc(8'hFE, 1'b0, 8'h02, 1'b0, "next_grant1");
`ifndef ARB_TIMEOUT_EN
      for (int k = 0; k < 20; k++) begin
         cyc(8'hFE, 1'b0, 8'h02, 1'b0, $sformatf("hold_forever%0d", k));
      end
`endif
      cyc(8'hFC, 1'b0, 8'h00, 1'b0, "drop1");

`ifdef ARB_TIMEOUT_EN
      // Forced release after MAX_HOLD cycles.
      pulse_reset("reset_before_to");
      for (int k = 0; k < MAX_HOLD; k++) begin
         cyc(8'h04, 1'b0, 8'h04, 1'b0, $sformatf("to_hold%0d", k));
      end
      cyc(8'h04, 1'b0, 8'h00, 1'b1, "to_pulse");
      cyc(8'h04, 1'b0, 8'h04, 1'b0, "to_regrant2");
      for (int k = 1; k < MAX_HOLD; k++) begin
         cyc(8'h04, 1'b0, 8'h04, 1'b0, $sformatf("to_hold2_%0d", k));
      end
      cyc(8'h0C, 1'b0, 8'h00, 1'b1, "to_pulse2");
      cyc(8'h0C, 1'b0, 8'h08, 1'b0, "to_next3");
      cyc(8'h0C, 1'b1, 8'h00, 1'b0, "to_done3");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
